// File: rtl/d1spfifo_rd_if.sv
// Downstream ready/valid beat stream produced by the d1spfifo read-side drain engine.
interface d1spfifo_rd_if #(
  parameter int WIDTH = 16
) ();
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/d1spfifo_rd.sv
// Read-side drain engine for the two-cycle-latency single-port FIFO: credit-limited pops into a skid buffer.
// Optional sticky protocol error flag is enabled by defining D1SPFIFO_RD_ERR_EN.
module d1spfifo_rd #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int BUF   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   fifo_empty,
  input  logic                   fifo_valid,
  input  logic [WIDTH-1:0]       fifo_rdata,
  output logic                   fifo_pop,
  output logic                   fifo_flush,
  d1spfifo_rd_if.master          m,
  output logic [$clog2(BUF):0]   level,
  output logic                   err
);
  localparam int AW = $clog2(BUF);
  localparam int IW = $clog2(LAT + 2);
  localparam logic [AW+1:0] BUF_W = (AW + 2)'(BUF);

  logic [WIDTH-1:0] mem_q [BUF];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             flush_q, flush_d;

  logic [AW:0]      count;
  logic [AW+1:0]    used;
  logic             full;
  logic             m_valid;
  logic             hs;
  logic             discard;
  logic             beat;
  logic             capture;
  logic             beat_dec;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    used     = {1'b0, count} + (AW + 2)'(inflight_q);
    m_valid  = (count != '0);
    hs       = m_valid && m.m_ready;
    // A beat seen the cycle after a flush can only be a stale pre-flush read, so it is dropped too.
    discard  = flush || flush_q;
    beat     = fifo_valid && !discard;
    capture  = beat && (!full || hs);
    beat_dec = beat && (inflight_q != '0);
    fifo_pop = !rst && !flush && !fifo_empty && (used < BUF_W);
  end

  always_comb begin
    flush_d    = flush;
    wr_ptr_d   = wr_ptr_q + (AW + 1)'(capture);
    rd_ptr_d   = rd_ptr_q + (AW + 1)'(hs);
    inflight_d = inflight_q + IW'(fifo_pop) - IW'(beat_dec);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      flush_q    <= flush_d;
    end
  end

  // Storage is data-only; the empty gate on m_data gives a clean 0 after reset or flush.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q[AW-1:0]] <= fifo_rdata;
  end

  assign m.m_valid  = m_valid;
  assign m.m_data   = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign level      = used[AW:0];
  assign fifo_flush = flush;

`ifdef D1SPFIFO_RD_ERR_EN
  logic err_q, err_d;
  logic overflow;

  always_comb begin
    overflow = beat && full && !hs;
    err_d    = err_q || (beat && (inflight_q == '0)) || overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_d1spfifo_rd.sv
// Directed bench for d1spfifo_rd with a behavioural two-cycle-latency FIFO model on the read side.
module tb_d1spfifo_rd;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fifo_empty;
  logic        fifo_valid;
  logic [15:0] fifo_rdata;
  logic        fifo_pop;
  logic        fifo_flush;
  logic [2:0]  level;
  logic        err;

  logic        force_empty;
  logic        inj_v;
  logic [15:0] inj_d;

  int checks = 0;
  int errors = 0;

`ifdef D1SPFIFO_RD_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  d1spfifo_rd_if #(.WIDTH(16)) mif ();

  d1spfifo_rd #(.WIDTH(16), .LAT(2), .BUF(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .fifo_flush (fifo_flush),
    .m          (mif.master),
    .level      (level),
    .err        (err)
  );

  // FIFO model: words preloaded into src, a pop returns its word two cycles later.
  logic [15:0] src [64];
  int          wr_n = 0;
  int          rd_n = 0;
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [15:0] pd0 = '0, pd1 = '0;

  always @(posedge clk) begin
    if (rst || flush) begin
      pv0  <= 1'b0;
      pv1  <= 1'b0;
      rd_n <= wr_n;
    end else begin
      pv0 <= fifo_pop;
      pv1 <= pv0;
      pd0 <= src[rd_n % 64];
      pd1 <= pd0;
      if (fifo_pop) rd_n <= rd_n + 1;
    end
  end

  assign fifo_empty = (rd_n == wr_n) || force_empty;
  assign fifo_valid = pv1 || inj_v;
  assign fifo_rdata = inj_v ? inj_d : pd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    src[wr_n % 64] = v;
    wr_n++;
  endtask

  int pops;
  int idx;
  int nb;
  logic        prev_stall;
  logic [15:0] prev_data;

  initial begin
    rst = 1'b1; flush = 1'b0; force_empty = 1'b0; inj_v = 1'b0; inj_d = '0;
    mif.m_ready = 1'b0;
    push(16'hDEAD);
    #1;
    chk("pop_in_rst", fifo_pop, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_m_valid", mif.m_valid, 0);
    chk("rst_m_data", mif.m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_err", err, 0);
    chk("rst_pop", fifo_pop, 0);

    // Streaming with m_ready held high: 3-cycle latency, one beat per cycle.
    tick();
    mif.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    #1;
    chk("t1_first_pop", fifo_pop, 1);
    chk("t1_valid_t0", mif.m_valid, 0);
    tick(); #1; chk("t1_valid_t1", mif.m_valid, 0);
    tick(); #1; chk("t1_valid_t2", mif.m_valid, 0);
    tick(); #1; chk("t1_valid_t3", mif.m_valid, 1);
    chk("t1_data_1", mif.m_data, 1);
    for (int k = 2; k <= 8; k++) begin
      tick(); #1;
      chk("t1_valid_k", mif.m_valid, 1);
      chk("t1_data_k", mif.m_data, 32'(k));
    end
    tick(); #1;
    chk("t1_drained", mif.m_valid, 0);
    chk("t1_err", err, 0);

    // Backpressure: credits cap pops at 4, head holds 0x0001.
    mif.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fifo_pop) pops++;
      tick();
    end
    #1;
    chk("t2_pops", pops, 4);
    chk("t2_level", level, 4);
    chk("t2_valid", mif.m_valid, 1);
    chk("t2_hold", mif.m_data, 1);
    mif.m_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      if (mif.m_valid) begin
        chk("t2_data", mif.m_data, 32'(idx + 1));
        idx++;
      end
      tick(); #1;
    end
    chk("t2_count", idx, 8);
    chk("t2_level_end", level, 0);

    // Alternating m_ready over 16 words: stable while stalled, in order.
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
    idx = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 100 && idx < 16; c++) begin
      mif.m_ready = (c % 2 == 0);
      #1;
      if (prev_stall) begin
        chk("t3_still_valid", mif.m_valid, 1);
        chk("t3_stable", mif.m_data, prev_data);
      end
      if (mif.m_valid && mif.m_ready) begin
        chk("t3_data", mif.m_data, 32'h0100 + 32'(idx));
        idx++;
      end
      prev_stall = mif.m_valid && !mif.m_ready;
      prev_data  = mif.m_data;
      tick();
    end
    chk("t3_count", idx, 16);
    mif.m_ready = 1'b1;
    tick(); tick(); tick(); #1;
    chk("t3_drained", mif.m_valid, 0);

    // Flush with 2 beats in flight and 2 buffered.
    mif.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(16'h0011 + 16'(i));
    for (int c = 0; c < 20; c++) begin
      #1;
      if (level == 3'd4) break;
      tick();
    end
    chk("t4_level_pre", level, 4);
    flush = 1'b1;
    #1;
    chk("t4_fifo_flush", fifo_flush, 1);
    chk("t4_pop_flush", fifo_pop, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_valid_after", mif.m_valid, 0);
    chk("t4_level_after", level, 0);
    chk("t4_fifo_flush_off", fifo_flush, 0);
    push(16'h00AA);
    mif.m_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mif.m_valid) begin
        nb++;
        chk("t4_data", mif.m_data, 32'h00AA);
      end
      tick();
    end
    chk("t4_beats", nb, 1);
    chk("t4_err", err, 0);

    // Unsolicited beat with nothing outstanding.
    inj_d = 16'h5555;
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    #1;
    chk("t5_err_set", err, 32'(ERR_EXP));
    tick(); tick(); tick(); #1;
    chk("t5_err_sticky", err, 32'(ERR_EXP));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_err_cleared", err, 0);
    chk("t5_valid_cleared", mif.m_valid, 0);

    // FIFO reports empty throughout: no pops, nothing presented.
    force_empty = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h0F00 + 16'(i));
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (fifo_pop) pops++;
      if (mif.m_valid) pops++;
      tick();
    end
    chk("t6_no_pop_or_valid", pops, 0);
    chk("t6_level", level, 0);
    rst = 1'b1;
    tick();
    force_empty = 1'b0;
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
